// File: rtl/control_encoder_arb.sv
// control_encoder_arb: collects 8 request lines, picks one winner, drives
// {addr, enable} into the 3-to-8 control_decoder for HOLD_CYCLES cycles and then
// pulses done/done_id for the completed grant.
// Build option: define RR_ARB_EN for round-robin arbitration; otherwise the
// lowest set request index wins (fixed priority) and no RR pointer exists.
module control_encoder_arb #(
  parameter int N_REQ       = 8,  // fixed at 8 to match the 3-bit decoder
  parameter int AW          = 3,  // must equal clog2(N_REQ)
  parameter int HOLD_CYCLES = 2   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [AW-1:0]    addr,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    done_id
);

  localparam int CW = 4;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic          enable_q,  enable_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic [AW-1:0] done_id_q, done_id_d;
  logic [CW-1:0] cnt_q,     cnt_d;

  logic [AW-1:0] win;
  logic          win_found;

`ifdef RR_ARB_EN
  logic [AW-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] rr_idx;

  // Round-robin search: start at the pointer, walk upward, wrap 7 -> 0.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    rr_idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rr_idx = rr_ptr_q + AW'(i);
      if (!win_found && req[rr_idx]) begin
        win       = rr_idx;
        win_found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest set request index wins.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i]) begin
        win       = AW'(i);
        win_found = 1'b1;
      end
    end
  end
`endif

  // Grant FSM: IDLE samples req, ASSERT holds the decoder line, DONE reports.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    enable_d  = enable_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    cnt_d     = cnt_q;
`ifdef RR_ARB_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        enable_d  = 1'b0;
        busy_d    = 1'b0;
        done_id_d = '0;
        if (win_found) begin
          // addr and enable load on the same edge so the decoder never sees
          // enable with a stale address.
          state_d  = S_ASSERT;
          addr_d   = win;
          enable_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = HOLD_LOAD;
        end
      end
      S_ASSERT: begin
        if (cnt_q == '0) begin
          state_d   = S_DONE;
          enable_d  = 1'b0;
          done_d    = 1'b1;
          done_id_d = addr_q;
`ifdef RR_ARB_EN
          rr_ptr_d  = addr_q + AW'(1);
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        done_id_d = '0;
      end
      default: begin
        state_d   = S_IDLE;
        enable_d  = 1'b0;
        busy_d    = 1'b0;
        done_id_d = '0;
        cnt_d     = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef RR_ARB_EN
  // Round-robin pointer, advanced past the winner as each grant completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign addr    = addr_q;
  assign enable  = enable_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule
